// File: rtl/jt51_wrseq_pkg.sv
`default_nettype none
// ============================================================================
// Module : jt51_wrseq_pkg
// Brief  : Shared types and constants for the YM2151 write sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package jt51_wrseq_pkg;

    localparam int YM_BUSY_BIT       = 7;
    localparam int POST_IGNORE_TICKS = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_WAIT  = 3'd1,
        ST_ADDR_WR   = 3'd2,
        ST_ADDR_REL  = 3'd3,
        ST_DATA_WR   = 3'd4,
        ST_DATA_REL  = 3'd5,
        ST_POST_WAIT = 3'd6
    } wrseq_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/jt51_wrseq_fifo.sv
`default_nettype none
// ============================================================================
// Module : jt51_wrseq_fifo
// Brief  : Small synchronous FIFO with registered full/empty flags.
// Rev    : 1.0  initial release
// ============================================================================
module jt51_wrseq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic [c_aw:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push      = i_push && !r_full;
    assign w_pop       = i_pop && !r_empty;
    assign w_count_nxt = r_count + (c_aw + 1)'(w_push) - (c_aw + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/jt51_wrseq.sv
`default_nettype none
// ============================================================================
// Module : jt51_wrseq
// Brief  : Queues host register writes and replays them onto the YM2151 bus.
// Rev    : 1.0  initial release
// ============================================================================
module jt51_wrseq
    import jt51_wrseq_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WR_TICKS = 2,
    parameter int BUSY_TO  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cen,
    input  logic       i_req_valid,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_data,
    output logic       o_req_ready,
    output logic       o_cs_n,
    output logic       o_wr_n,
    output logic       o_a0,
    output logic [7:0] o_bus_dout,
    input  logic [7:0] i_status,
    output logic       o_idle,
    output logic       o_timeout_err
);

    localparam logic [7:0] c_wr_last     = 8'(WR_TICKS - 1);
    localparam logic [7:0] c_busy_last   = 8'(BUSY_TO - 1);
    localparam logic [7:0] c_post_ignore = 8'(POST_IGNORE_TICKS);

    wrseq_state_t r_state;
    wrseq_state_t w_state_nxt;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_nxt;
    wr_req_t      r_hold;
    wr_req_t      w_fifo_rdata;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_pop;
    logic         w_timeout;
    logic         w_load_addr;
    logic         w_load_data;
    logic         w_busy;
    logic         w_strobe;
    logic         r_a0;
    logic [7:0]   r_dout;
    logic         r_timeout;
    logic         w_unused_status;

    assign w_busy          = i_status[YM_BUSY_BIT];
    assign w_unused_status = ^i_status;

    jt51_wrseq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_req_valid),
        .i_wdata ({i_req_addr, i_req_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (i_cen) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt times the strobe width and the busy waits; it restarts on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        w_load_addr = 1'b0;
        w_load_data = 1'b0;
        if (i_cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_PRE_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRE_WAIT: begin
                    if (!w_busy) begin
                        w_state_nxt = ST_ADDR_WR;
                        w_load_addr = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_busy_last) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_ADDR_WR: begin
                    if (r_cnt == c_wr_last) begin
                        w_state_nxt = ST_ADDR_REL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_ADDR_REL: begin
                    w_state_nxt = ST_DATA_WR;
                    w_load_data = 1'b1;
                    w_cnt_nxt   = '0;
                end
                ST_DATA_WR: begin
                    if (r_cnt == c_wr_last) begin
                        w_state_nxt = ST_DATA_REL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_DATA_REL: begin
                    w_state_nxt = ST_POST_WAIT;
                    w_cnt_nxt   = '0;
                end
                ST_POST_WAIT: begin
                    if ((r_cnt >= c_post_ignore) && !w_busy) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_busy_last) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // a0/bus only change on strobe entry so the chip sees stable lines across releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_a0      <= 1'b0;
            r_dout    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_pop) begin
                r_hold <= w_fifo_rdata;
            end
            if (w_load_addr) begin
                r_a0   <= 1'b0;
                r_dout <= r_hold.addr;
            end else if (w_load_data) begin
                r_a0   <= 1'b1;
                r_dout <= r_hold.data;
            end
        end
    end

    always_comb begin
        w_strobe = (r_state == ST_ADDR_WR) || (r_state == ST_DATA_WR);
    end

    assign o_cs_n        = !w_strobe;
    assign o_wr_n        = !w_strobe;
    assign o_a0          = r_a0;
    assign o_bus_dout    = r_dout;
    assign o_req_ready   = !w_fifo_full;
    assign o_idle        = w_fifo_empty && (r_state == ST_IDLE);
    assign o_timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_jt51_wrseq.sv
`default_nettype none
// ============================================================================
// Module : tb_jt51_wrseq
// Brief  : Self-checking bench: bus monitor + write scoreboard for jt51_wrseq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_jt51_wrseq;

    localparam int DEPTH    = 4;
    localparam int WR_TICKS = 2;
    localparam int BUSY_TO  = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       req_valid;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] bus_dout;
    logic [7:0] status;
    logic       idle;
    logic       timeout_err;

    jt51_wrseq #(
        .DEPTH    (DEPTH),
        .WR_TICKS (WR_TICKS),
        .BUSY_TO  (BUSY_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cen         (cen),
        .i_req_valid   (req_valid),
        .i_req_addr    (req_addr),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .o_cs_n        (cs_n),
        .o_wr_n        (wr_n),
        .o_a0          (a0),
        .o_bus_dout    (bus_dout),
        .i_status      (status),
        .o_idle        (idle),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // cen: 0 = held low, 1 = every cen_div-th clk, 2 = random
    int          cen_mode = 0;
    int          cen_div  = 1;
    int unsigned cen_cnt  = 0;
    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cen_cnt++;
            case (cen_mode)
                0:       cen = 1'b0;
                1:       cen = ((cen_cnt % cen_div) == 0);
                default: cen = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    bit rand_status = 1'b0;
    int burst       = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_status) begin
                if (burst > 0) burst--;
                else if ($urandom_range(0, 15) == 0) burst = $urandom_range(1, 30);
                status = {(burst > 0), 7'($urandom_range(0, 127))};
            end
        end
    end

    // Scoreboard: writes accepted by the FIFO, in order; the monitor retires them from the bus.
    logic [15:0] exp_q[$];
    int          n_strobe  = 0;
    bit          chk_width = 1'b0;
    int          exp_width = 2;
    bit          in_strobe = 1'b0;
    bit          have_addr = 1'b0;
    bit          s_ok;
    bit          rel_ok;
    logic        s_a0;
    logic [7:0]  s_bus;
    logic [7:0]  m_addr;
    logic [15:0] e_wr;
    int          low_clk;

    always @(negedge clk) begin
        if (rst) begin
            in_strobe = 1'b0;
            have_addr = 1'b0;
        end else if (cs_n === 1'b0) begin
            if (!in_strobe) begin
                in_strobe = 1'b1;
                s_a0      = a0;
                s_bus     = bus_dout;
                low_clk   = 0;
                s_ok      = 1'b1;
            end
            low_clk++;
            if (wr_n !== 1'b0 || a0 !== s_a0 || bus_dout !== s_bus) s_ok = 1'b0;
        end else begin
            if (in_strobe) begin
                in_strobe = 1'b0;
                n_strobe++;
                check("strobe_steady", 32'(s_ok), 1);
                if (chk_width) check("strobe_width_clk", low_clk, exp_width);
                if (s_a0 === 1'b0) begin
                    have_addr = 1'b1;
                    m_addr    = s_bus;
                    rel_ok    = 1'b1;
                end else begin
                    check("data_after_addr", 32'(have_addr), 1);
                    check("release_hold", 32'(rel_ok), 1);
                    check("write_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e_wr = exp_q.pop_front();
                        check("write_addr_data", {16'h0, m_addr, s_bus}, {16'h0, e_wr});
                    end
                    have_addr = 1'b0;
                end
            end
            if (have_addr && (a0 !== 1'b0 || bus_dout !== m_addr)) rel_ok = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        int t = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && t < 3000) begin
            step();
            t++;
        end
        check("push_accept", 32'(req_ready), 1);
        if (req_ready) exp_q.push_back({a, d});
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!idle && t < 20000) begin
            step();
            t++;
        end
        check("idle_reached", 32'(idle), 1);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        int         div;
        int         busy;
        int         exp_ticks;
        logic       exp_to;
    } vec_t;

    // exp_ticks: cen ticks from data-strobe release to idle = 1 (DATA_REL) + 2 ignored
    // POST_WAIT ticks + first non-busy tick, i.e. max(4, busy+1); a stuck busy aborts on tick 1+BUSY_TO.
    task automatic run_single(input vec_t v);
        int t = 0;
        int ticks = 0;
        bit c;
        bit to_seen = 1'b0;
        cen_div   = v.div;
        chk_width = 1'b1;
        exp_width = WR_TICKS * v.div;
        push(v.addr, v.data);
        while (!(cs_n === 1'b0 && a0 === 1'b1) && t < 300) begin
            step();
            t++;
        end
        while (cs_n === 1'b0 && t < 300) begin
            step();
            t++;
        end
        check("data_strobe_seen", 32'(t < 300), 1);
        if (v.busy > 0) status = 8'h80;
        t = 0;
        while (!idle && t < 3000) begin
            @(posedge clk);
            c = cen;
            if (c) ticks++;
            #1;
            if (ticks >= v.busy) status = 8'h00;
            if (timeout_err) to_seen = 1'b1;
            t++;
        end
        status = 8'h00;
        check("post_ticks", ticks, v.exp_ticks);
        check("post_timeout", 32'(to_seen), 32'(v.exp_to));
        check("idle_after_write", 32'(idle), 1);
    endtask

    vec_t tbl[8];
    int   s0;
    int   t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, summary: %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h14, 8'h3F, 1, 0,    4,   1'b0};
        tbl[1] = '{8'hA5, 8'h5A, 1, 20,   21,  1'b0};
        tbl[2] = '{8'h01, 8'hFF, 3, 0,    4,   1'b0};
        tbl[3] = '{8'h7E, 8'h81, 3, 5,    6,   1'b0};
        tbl[4] = '{8'h20, 8'h00, 1, 2,    4,   1'b0};
        tbl[5] = '{8'h21, 8'h11, 1, 3,    4,   1'b0};
        tbl[6] = '{8'h22, 8'h12, 2, 4,    5,   1'b0};
        tbl[7] = '{8'h30, 8'hC3, 2, 1000, 256, 1'b1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 8'h00;
        req_data  = 8'h00;
        status    = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_wr_n", 32'(wr_n), 1);
        check("rst_a0", 32'(a0), 0);
        check("rst_bus", 32'(bus_dout), 0);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_idle", 32'(idle), 1);
        check("rst_timeout", 32'(timeout_err), 0);

        cen_mode = 1;
        for (int i = 0; i < 8; i++) run_single(tbl[i]);

        // FIFO fill while frozen, then drain in order
        cen_mode  = 0;
        cen_div   = 1;
        chk_width = 1'b1;
        exp_width = WR_TICKS;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            check("ready_before_push", 32'(req_ready), 32'(i < DEPTH));
            if (i < DEPTH) push(8'h40 + 8'(i), 8'hB0 + 8'(i));
        end
        check("frozen_not_idle", 32'(idle), 0);
        check("frozen_no_strobe", 32'(cs_n), 1);
        cen_mode = 1;
        push(8'h44, 8'hB4);
        wait_idle();

        // Busy stuck before the address strobe: one pop tick, then BUSY_TO busy ticks
        status = 8'h80;
        s0     = n_strobe;
        push(8'h55, 8'hAA);
        t = 0;
        while (!timeout_err && t < 400) begin
            step();
            t++;
        end
        check("pre_timeout_latency", t, BUSY_TO + 1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        step();
        check("timeout_one_clk", 32'(timeout_err), 0);
        check("idle_after_pre_timeout", 32'(idle), 1);
        status = 8'h00;
        repeat (20) step();
        check("dropped_write_no_strobe", n_strobe - s0, 0);

        // Reset while the data strobe is active, with more writes still queued
        cen_mode = 0;
        repeat (2) step();
        push(8'h61, 8'h71);
        push(8'h62, 8'h72);
        push(8'h63, 8'h73);
        cen_mode = 1;
        t = 0;
        while (!(cs_n === 1'b0 && a0 === 1'b1) && t < 500) begin
            step();
            t++;
        end
        check("reached_data_wr", 32'(t < 500), 1);
        s0 = n_strobe;
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_cs_n", 32'(cs_n), 1);
        check("rstmid_wr_n", 32'(wr_n), 1);
        check("rstmid_idle", 32'(idle), 1);
        check("rstmid_a0", 32'(a0), 0);
        check("rstmid_bus", 32'(bus_dout), 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        repeat (60) step();
        check("rstmid_no_replay", n_strobe - s0, 0);
        check("rstmid_ready", 32'(req_ready), 1);

        // Randomised traffic against the scoreboard
        cen_mode    = 2;
        chk_width   = 1'b0;
        rand_status = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();
        rand_status = 1'b0;
        status      = 8'h00;
        repeat (5) step();
        check("final_idle", 32'(idle), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
